uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with a receive FIFO and ready/valid output, replacing the soft-processor UART receive path with native RTL. It samples the board serial input (RsRx) with 16x oversampling, deframes characters of configurable width and parity, and buffers them for a downstream consumer such as a command parser or register loader. Framing, parity and overrun conditions are reported as sticky error flags.

## Interface
- CLK_HZ, 100000000: system clock frequency in Hz.
- BAUD, 115200: serial bit rate.
- DATA_BITS, 8: character width, legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- FIFO_DEPTH, 16: receive FIFO entries, power of 2, >= 2.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  raw serial input, idle high, asynchronous to clk.
- m_data  out  DATA_BITS  FIFO head character, first-word-fall-through.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts m_data this cycle.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err  out  1  sticky: stop bit sampled low.
- parity_err  out  1  sticky: parity mismatch.
- overrun  out  1  sticky: good character dropped because FIFO full.
- clr_err  in  1  synchronous one-cycle pulse clearing all three sticky flags.

## Operation
- Reset values: m_valid 0, level 0, m_data 0, all error flags 0, FSM IDLE, synchroniser stages 1, FIFO pointers 0.
- rx passes through a 2-flop synchroniser (reset to 1); FSM uses the synchronised value only.
- Tick generator: divisor DIV = round(CLK_HZ / (BAUD*16)); free-running counter emits a 1-cycle tick every DIV clocks; counter restarts at 0 on entry to START.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK.
- IDLE -> START on synchronised rx = 0.
- START: after 8 ticks sample rx; 0 -> DATA, 1 -> IDLE (glitch rejected, nothing written, no flag).
- DATA: sample every 16 ticks, LSB first, DATA_BITS samples; -> PAR if PARITY != 0, else STOP.
- PAR: sample after 16 ticks; compare with computed parity (odd: data ^ bit XOR-reduces to 1; even: to 0).
- STOP: sample after 16 ticks. 1 and parity ok -> write char, -> IDLE. 1 and parity bad -> set parity_err, discard, -> IDLE. 0 -> set frame_err, discard, -> BREAK.
- BREAK: wait for rx = 1, then IDLE (no new start detected while line held low).
- FIFO write accepted when level < FIFO_DEPTH, or level = FIFO_DEPTH with pop in the same cycle; otherwise character dropped, overrun set, FIFO unchanged.
- Pop when m_valid && m_ready; m_ready ignored while m_valid = 0.
- Simultaneous push and pop: level unchanged, head advances, new char appended.
- Pointers wrap modulo FIFO_DEPTH; level counts 0..FIFO_DEPTH inclusive.
- clr_err clears flags; an error event in the same cycle as clr_err wins (flag stays 1).
- Reset mid-character: partial character discarded, FSM to IDLE; FIFO contents lost.

## Timing
- Bit period = 16*DIV clocks (864 at defaults, DIV = 54).
- Stop-bit sample at ~(1.5 + DATA_BITS + P) bit periods after the falling edge reaches the synchroniser output, P = 1 if parity enabled.
- FIFO write on the cycle after the stop-bit sample; m_valid and level update on the following edge (registered).
- m_data valid in the same cycle m_valid = 1; after a pop the next entry appears on the next edge.
- Sticky flags assert one cycle after the offending sample.
- Back-to-back characters with a single stop bit received with no gap lost.

## Test plan
- Defaults, m_ready = 1, send 0x55 8N1 -> m_valid pulses 1 cycle with m_data = 0x55, level returns to 0, no flags.
- rx low for 200 clocks then high -> no write, level 0, no flags, next 0xA3 received correctly.
- Send 0x00 with stop bit held low 2 bit periods -> frame_err = 1, level 0; clr_err pulse -> frame_err = 0; following 0x41 received.
- m_ready = 0, send 17 chars 0x00..0x10 back-to-back -> level = 16, overrun = 1; drain yields 0x00..0x0F in order, level 0.
- PARITY = 2, send 0x07 with parity bit 0 -> parity_err = 1, nothing written; 0x07 with parity bit 1 -> written, m_data = 0x07.
- Assert reset halfway through a character's data bits -> all outputs at reset values within one cycle; next full character 0x3C received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampled UART receiver with a first-word-fall-through
// receive FIFO, ready/valid output and sticky framing/parity/overrun flags.
// The serial input is synchronised, deframed by a small FSM and pushed into
// the FIFO one cycle after a clean stop bit.

module uart_rx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx,
  output logic [DATA_BITS-1:0]        m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun,
  input  logic                        clr_err
);

  // Oversampling divisor, rounded to the nearest integer and never below 1.
  localparam int DIV_RAW = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  localparam logic [3:0] LAST_BIT   = 4'(DATA_BITS - 1);
  localparam logic       HAS_PARITY = (PARITY != 0);
  localparam logic       ODD_PARITY = (PARITY == 1);

  // Receiver FSM encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BREAK = 3'd5;

  // Synchroniser
  logic rxMeta;
  logic rxSync;

  // Tick generator
  logic [DIV_W-1:0] divCnt;
  logic             tick;
  logic             startSeen;

  // Receiver FSM
  logic [2:0]           state;
  logic [3:0]           tickNum;
  logic [3:0]           bitNum;
  logic [DATA_BITS-1:0] shiftReg;
  logic                 parityBad;
  logic                 midSample;
  logic                 fullSample;

  // One-cycle requests from the FSM to the FIFO and flag logic
  logic                 wrReq;
  logic [DATA_BITS-1:0] wrData;
  logic                 setFrame;
  logic                 setParity;

  // FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wrPtr;
  logic [PTR_W-1:0]     rdPtr;
  logic [LVL_W-1:0]     levelReg;
  logic [LVL_W-1:0]     levelNext;
  logic                 validReg;
  logic                 doPush;
  logic                 doPop;
  logic                 fifoFull;
  logic                 dropChar;

  // Bring the asynchronous line into the clock domain; idle-high reset value.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // flop samples the pre-edge values of the others.
    if (reset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
    end else begin
      rxMeta <= rx;
      rxSync <= rxMeta;
    end
  end

  assign startSeen = (state == ST_IDLE) && !rxSync;
  assign tick      = (divCnt == DIV_LAST);

  // Free-running 16x tick counter, realigned to the falling edge of a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCnt <= '0;
    end else if (startSeen || tick) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  // Mid-start-bit sample after 8 ticks, every other sample after 16 ticks.
  assign midSample  = tick && (tickNum == 4'd7);
  assign fullSample = tick && (tickNum == 4'd15);

  // Deframing FSM: start qualification, LSB-first data, optional parity, stop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      tickNum   <= '0;
      bitNum    <= '0;
      shiftReg  <= '0;
      parityBad <= 1'b0;
      wrReq     <= 1'b0;
      wrData    <= '0;
      setFrame  <= 1'b0;
      setParity <= 1'b0;
    end else begin
      wrReq     <= 1'b0;
      setFrame  <= 1'b0;
      setParity <= 1'b0;
      if (tick && state != ST_IDLE && state != ST_BREAK) begin
        tickNum <= tickNum + 4'd1;
      end
      case (state)
        ST_IDLE: begin
          parityBad <= 1'b0;
          if (!rxSync) begin
            state   <= ST_START;
            tickNum <= '0;
          end
        end
        ST_START: begin
          if (midSample) begin
            tickNum <= '0;
            bitNum  <= '0;
            // A line already back high at mid-bit was a glitch, not a start.
            state   <= rxSync ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (fullSample) begin
            tickNum  <= '0;
            shiftReg <= {rxSync, shiftReg[DATA_BITS-1:1]};
            if (bitNum == LAST_BIT) begin
              state <= HAS_PARITY ? ST_PAR : ST_STOP;
            end else begin
              bitNum <= bitNum + 4'd1;
            end
          end
        end
        ST_PAR: begin
          if (fullSample) begin
            tickNum   <= '0;
            parityBad <= (^{shiftReg, rxSync}) != ODD_PARITY;
            state     <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (fullSample) begin
            tickNum <= '0;
            if (rxSync) begin
              if (parityBad) begin
                setParity <= 1'b1;
              end else begin
                wrReq  <= 1'b1;
                wrData <= shiftReg;
              end
              state <= ST_IDLE;
            end else begin
              setFrame <= 1'b1;
              state    <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // Hold off start detection until the line returns to idle.
          if (rxSync) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifoFull = (levelReg == LVL_FULL);
  assign doPop    = validReg && m_ready;
  assign doPush   = wrReq && (!fifoFull || doPop);
  assign dropChar = wrReq && fifoFull && !doPop;

  // Next occupancy from the push/pop pair of this cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves levelNext unassigned,
    // which would otherwise infer a latch.
    levelNext = levelReg;
    case ({doPush, doPop})
      2'b10:   levelNext = levelReg + LVL_W'(1);
      2'b01:   levelNext = levelReg - LVL_W'(1);
      default: levelNext = levelReg;
    endcase
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; m_data is gated by m_valid so
    // stale entries are never visible and the array maps onto plain RAM.
    if (doPush) begin
      mem[wrPtr] <= wrData;
    end
  end

  // FIFO pointers, occupancy and registered valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      levelReg <= '0;
      validReg <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      levelReg <= levelNext;
      validReg <= (levelNext != '0);
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (frame_err  && !clr_err) || setFrame;
      parity_err <= (parity_err && !clr_err) || setParity;
      overrun    <= (overrun    && !clr_err) || dropChar;
    end
  end

  assign m_valid = validReg;
  assign level   = levelReg;
  assign m_data  = validReg ? mem[rdPtr] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial stimulus with exact bit timing, a
// queue-based model of the receive path checked on every cycle, and
// literal expectations for each scenario.

module tb_uart_rx_fifo;

  localparam int BAUD   = 115200;
  localparam int CLK_HZ = 14745600;        // 14745600 / (115200*16) = 8
  localparam int DIV    = 8;
  localparam int BIT    = 16 * DIV;        // clocks per bit
  localparam int NB     = 8;
  localparam int DEPTH  = 16;
  // Falling edge driven after edge c0 is seen by the FSM at edge c0+3
  // (two synchroniser flops, then the idle-state detect).
  localparam int SYNC_LAT = 3;

  typedef enum int {EV_GOOD, EV_FRAME} evKind_t;
  typedef struct {
    int          due;
    evKind_t     kind;
    logic [7:0]  data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx, rxP;
  logic       mReady, mReadyP;
  logic       clrErr;
  logic [7:0] mData, mDataP;
  logic       mValid, mValidP;
  logic [4:0] level, levelP;
  logic       frameErr, parityErr, overrun;
  logic       frameErrP, parityErrP, overrunP;

  int         cyc = 0;
  int         nTests = 0;
  int         nFail = 0;
  int         validCycles = 0;
  logic [7:0] lastPop = 8'h00;
  logic [7:0] popLog[$];

  // Model state
  ev_t        evQ[$];
  logic [7:0] modelQ[$];
  bit         mFrame, mPar, mOvr;
  bit         popPend, clrPend;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                 .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .m_data(mData), .m_valid(mValid), .m_ready(mReady), .level(level),
    .frame_err(frameErr), .parity_err(parityErr), .overrun(overrun),
    .clr_err(clrErr)
  );

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                 .FIFO_DEPTH(DEPTH)) dutP (
    .clk(clk), .reset(reset), .rx(rxP),
    .m_data(mDataP), .m_valid(mValidP), .m_ready(mReadyP), .level(levelP),
    .frame_err(frameErrP), .parity_err(parityErrP), .overrun(overrunP),
    .clr_err(1'b0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic setLine(input bit toP, input logic v);
    if (toP) rxP = v;
    else     rx  = v;
  endtask

  // Send one 8-bit character. stopLow > 0 holds the stop bit low for that
  // many bit periods. Characters on the main line are also announced to the
  // model with the cycle their effect becomes visible: stop bit sampled
  // 8 ticks + (NB+P+1) bit periods after start detect, visible one edge later.
  task automatic sendChar(input logic [7:0] data, input bit withPar, input bit pBit,
                          input int stopLow, input bit toP);
    int  c0;
    ev_t ev;
    @(posedge clk); #1;
    c0 = cyc;
    if (!toP) begin
      ev.due  = c0 + SYNC_LAT + 8 * DIV + BIT * (NB + (withPar ? 1 : 0) + 1) + 1;
      ev.kind = (stopLow > 0) ? EV_FRAME : EV_GOOD;
      ev.data = data;
      evQ.push_back(ev);
    end
    setLine(toP, 1'b0);
    repeat (BIT) @(posedge clk); #1;
    for (int i = 0; i < NB; i++) begin
      setLine(toP, data[i]);
      repeat (BIT) @(posedge clk); #1;
    end
    if (withPar) begin
      setLine(toP, pBit);
      repeat (BIT) @(posedge clk); #1;
    end
    if (stopLow > 0) begin
      setLine(toP, 1'b0);
      repeat (stopLow * BIT) @(posedge clk); #1;
    end
    setLine(toP, 1'b1);
    repeat (BIT - 1) @(posedge clk);
  endtask

  task automatic idleBits(input int n);
    repeat (n * BIT) @(posedge clk);
    #1;
  endtask

  task automatic pulseClr();
    @(posedge clk); #1 clrErr = 1'b1;
    @(posedge clk); #1 clrErr = 1'b0;
  endtask

  // Model update and comparison, once per cycle on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      modelQ.delete();
      mFrame = 0; mPar = 0; mOvr = 0;
      popPend = 0; clrPend = 0;
      check("rst_m_valid", mValid, 0);
      check("rst_level", level, 0);
      check("rst_m_data", mData, 0);
      check("rst_flags", {frameErr, parityErr, overrun}, 0);
    end else begin
      if (clrPend) begin
        mFrame = 0; mPar = 0; mOvr = 0;
      end
      if (popPend) void'(modelQ.pop_front());
      while (evQ.size() > 0 && evQ[0].due <= cyc) begin
        ev_t ev;
        ev = evQ.pop_front();
        if (ev.kind == EV_FRAME) mFrame = 1;
        else if (modelQ.size() < DEPTH) modelQ.push_back(ev.data);
        else mOvr = 1;
      end
      check("m_valid", mValid, modelQ.size() != 0);
      check("level", level, modelQ.size());
      if (modelQ.size() != 0) check("m_data", mData, modelQ[0]);
      check("frame_err", frameErr, mFrame);
      check("parity_err", parityErr, mPar);
      check("overrun", overrun, mOvr);
      popPend = (modelQ.size() != 0) && mReady;
      clrPend = clrErr;
    end
  end

  // Observation of what the consumer actually receives.
  always @(negedge clk) begin
    if (!reset && mValid) begin
      validCycles++;
      if (mReady) begin
        lastPop = mData;
        popLog.push_back(mData);
      end
    end
  end

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int v0;
    int n0;
    reset = 1'b1; rx = 1'b1; rxP = 1'b1;
    mReady = 1'b1; mReadyP = 1'b0; clrErr = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("init_level", level, 0);
    check("init_m_valid", mValid, 0);
    check("init_flags", {frameErr, parityErr, overrun}, 0);
    check("init_p_level", levelP, 0);
    reset = 1'b0;
    idleBits(1);

    // 0x55 8N1 with consumer ready: one-cycle valid pulse.
    v0 = validCycles;
    sendChar(8'h55, 0, 0, 0, 0);
    idleBits(1);
    check("t1_valid_cycles", validCycles - v0, 1);
    check("t1_data", lastPop, 8'h55);
    check("t1_level", level, 0);
    check("t1_flags", {frameErr, parityErr, overrun}, 0);

    // Short low glitch is rejected; next character still received.
    n0 = popLog.size();
    @(posedge clk); #1 rx = 1'b0;
    repeat (40) @(posedge clk); #1 rx = 1'b1;
    idleBits(2);
    check("t2_no_write", popLog.size(), n0);
    check("t2_flags", {frameErr, parityErr, overrun}, 0);
    sendChar(8'hA3, 0, 0, 0, 0);
    idleBits(1);
    check("t2_data", lastPop, 8'hA3);

    // Stop bit held low: framing error, nothing written, clear works.
    n0 = popLog.size();
    sendChar(8'h00, 0, 0, 2, 0);
    idleBits(1);
    check("t3_frame_err", frameErr, 1);
    check("t3_level", level, 0);
    check("t3_no_write", popLog.size(), n0);
    pulseClr();
    check("t3_cleared", frameErr, 0);

    // Clear pulse landing on the very edge that records a framing error.
    fork
      sendChar(8'h00, 0, 0, 2, 0);
      begin
        int c0;
        @(posedge clk); #1;
        c0 = cyc;
        repeat (SYNC_LAT + 8 * DIV + BIT * (NB + 1)) @(posedge clk);
        #1 clrErr = 1'b1;
        @(posedge clk); #1 clrErr = 1'b0;
      end
    join
    idleBits(1);
    check("t3_error_beats_clear", frameErr, 1);
    pulseClr();
    check("t3_cleared2", frameErr, 0);
    sendChar(8'h41, 0, 0, 0, 0);
    idleBits(1);
    check("t3_data", lastPop, 8'h41);

    // Even parity: 0x07 has three ones, so parity bit 1 is correct.
    sendChar(8'h07, 1, 1'b0, 0, 1);
    idleBits(1);
    check("t5_parity_err", parityErrP, 1);
    check("t5_bad_not_written", levelP, 0);
    check("t5_bad_valid", mValidP, 0);
    sendChar(8'h07, 1, 1'b1, 0, 1);
    idleBits(1);
    check("t5_good_valid", mValidP, 1);
    check("t5_good_data", mDataP, 8'h07);
    check("t5_good_level", levelP, 1);
    check("t5_sticky", parityErrP, 1);
    check("t5_no_frame", frameErrP, 0);

    // Overflow: 17 back-to-back characters into a 16-entry FIFO.
    @(posedge clk); #1 mReady = 1'b0;
    for (int i = 0; i < 17; i++) sendChar(8'(i), 0, 0, 0, 0);
    idleBits(1);
    check("t4_level_full", level, 16);
    check("t4_overrun", overrun, 1);
    check("t4_head", mData, 8'h00);
    popLog.delete();
    @(posedge clk); #1 mReady = 1'b1;
    repeat (24) @(posedge clk); #1;
    check("t4_drain_count", popLog.size(), 16);
    for (int i = 0; i < 16 && i < popLog.size(); i++)
      check("t4_drain_order", popLog[i], i);
    check("t4_level_empty", level, 0);
    check("t4_overrun_sticky", overrun, 1);

    // Reset mid-character discards the partial character and the FIFO.
    mReady = 1'b0;
    sendChar(8'h5A, 0, 0, 0, 0);
    idleBits(1);
    check("t6_pre_level", level, 1);
    @(posedge clk); #1 rx = 1'b0;
    repeat (BIT) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (BIT) @(posedge clk); #1;
    end
    rx = 1'b0;
    repeat (BIT / 2) @(posedge clk);
    #3 reset = 1'b1; rx = 1'b1;
    #1;
    check("t6_level", level, 0);
    check("t6_m_valid", mValid, 0);
    check("t6_m_data", mData, 0);
    check("t6_overrun", overrun, 0);
    check("t6_p_level", levelP, 0);
    repeat (3) @(posedge clk); #1 reset = 1'b0;
    idleBits(2);
    mReady = 1'b1;
    sendChar(8'h3C, 0, 0, 0, 0);
    idleBits(1);
    check("t6_data", lastPop, 8'h3C);
    check("t6_level_after", level, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
